reg_file_bank: RTL and testbench

Architectural register storage for the processor datapath: 32 registers of `WIDTH` bits, one synchronous write port and two read ports. It is the stage directly upstream of the 32:1 read-selection muxes. Each read port is built bit-sliced: for bit *b*, bit *b* of all 32 registers forms a 32-bit vector that drives one 32:1 mux, selected by the 5-bit read address. It adds a write decoder, per-register enables, a hardwired zero register and write-to-read bypass.

---
 rtl/reg_file_bank.sv | 83 ++++++++
 tb/tb_reg_file_bank.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_bank.sv
// reg_file_bank: 32 x WIDTH architectural register file with one synchronous
// write port, two combinational read ports, a hardwired zero register and
// write-to-read bypass. Each read port is bit-sliced: for every data bit a
// 32-bit column of that bit across all registers feeds one 32:1 mux. Each mux
// is split into two 16:1 halves chosen by address bit 4.
module reg_file_bank #(
  parameter int WIDTH    = 32,
  parameter int ZERO_REG = 31
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             RegWrite,
  input  logic [4:0]       WriteReg,
  input  logic [WIDTH-1:0] WriteData,
  input  logic [4:0]       ReadReg1,
  input  logic [4:0]       ReadReg2,
  output logic [WIDTH-1:0] ReadData1,
  output logic [WIDTH-1:0] ReadData2
);

  localparam logic [4:0] ZERO_ADDR = 5'(ZERO_REG);

  // One-hot write enables. This vector is all zero when RegWrite is low.
  logic [31:0] we;
  assign we = RegWrite ? (32'd1 << WriteReg) : 32'd0;

  // Register contents as seen by the read muxes. The zero register row is
  // tied to 0 and has no flops behind it.
  logic [31:0][WIDTH-1:0] row;

  genvar gi, gj;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_reg
      if (gi == ZERO_REG) begin : g_zero
        assign row[gi] = '0;
      end else begin : g_store
        logic [WIDTH-1:0] r_reg;
        // Reset clears the register and takes priority over a write. Otherwise
        // the register loads WriteData when it is the decoded target.
        always_ff @(posedge clk) begin
          if (!reset_n) begin
            r_reg <= '0;
          end else if (we[gi]) begin
            r_reg <= WriteData;
          end
        end
        assign row[gi] = r_reg;
      end
    end
  endgenerate

  // Raw storage read values, before the bypass is applied.
  logic [WIDTH-1:0] raw1;
  logic [WIDTH-1:0] raw2;

  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [31:0] col;
      for (gj = 0; gj < 32; gj++) begin : g_col
        assign col[gj] = row[gj][gi];
      end
      logic [15:0] col_lo;
      logic [15:0] col_hi;
      assign col_lo = col[15:0];
      assign col_hi = col[31:16];
      // Each 16:1 half resolves the low four address bits. Address bit 4
      // then selects between the two halves, so the halves cannot mix.
      assign raw1[gi] = ReadReg1[4] ? col_hi[ReadReg1[3:0]] : col_lo[ReadReg1[3:0]];
      assign raw2[gi] = ReadReg2[4] ? col_hi[ReadReg2[3:0]] : col_lo[ReadReg2[3:0]];
    end
  endgenerate

  // The bypass forwards data being written this cycle. It is suppressed
  // during reset, because that write is discarded, and for the zero register.
  logic byp1;
  logic byp2;
  assign byp1 = RegWrite && reset_n && (WriteReg == ReadReg1) && (ReadReg1 != ZERO_ADDR);
  assign byp2 = RegWrite && reset_n && (WriteReg == ReadReg2) && (ReadReg2 != ZERO_ADDR);

  assign ReadData1 = byp1 ? WriteData : raw1;
  assign ReadData2 = byp2 ? WriteData : raw2;

endmodule

// File: tb/tb_reg_file_bank.sv
// tb_reg_file_bank: directed scenarios plus randomized traffic for
// reg_file_bank. The design is checked against an array-based model of the
// architectural registers.
module tb_reg_file_bank;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model [32];

  reg_file_bank #(.WIDTH(32), .ZERO_REG(31)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .RegWrite  (RegWrite),
    .WriteReg  (WriteReg),
    .WriteData (WriteData),
    .ReadReg1  (ReadReg1),
    .ReadReg2  (ReadReg2),
    .ReadData1 (ReadData1),
    .ReadData2 (ReadData2)
  );

  always #5 clk = ~clk;

  // Expected read value for an address, given the current inputs.
  // Register 31 always reads 0. A write in progress is visible at once
  // unless reset is low. Any other address returns the stored value.
  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd31) return 32'd0;
    if (reset_n && RegWrite && WriteReg == a) return WriteData;
    return model[a];
  endfunction

  // Drive all inputs between clock edges, then let the combinational paths settle.
  task automatic set_in(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] a1, input logic [4:0] a2);
    RegWrite  = we;
    WriteReg  = wa;
    WriteData = wd;
    ReadReg1  = a1;
    ReadReg2  = a2;
    #1;
  endtask

  // Apply the clock edge to the model, then to the DUT.
  task automatic step();
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
    end else if (RegWrite && WriteReg != 5'd31) begin
      model[WriteReg] = WriteData;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    set_in(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    step();
    reset_n = 1'b1;
    for (int a = 0; a < 32; a++) begin
      set_in(1'b0, 5'd0, 32'd0, 5'(a), 5'(31 - a));
      checks++;
      if (ReadData1 !== 32'd0 || ReadData2 !== 32'd0) begin
        failures++;
        $display("FAIL reset_zero addr=%0d got rd1=%h rd2=%h want 0", a, ReadData1, ReadData2);
      end
    end
    set_in(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5);
    step();
    reset_n = 1'b0;
    set_in(1'b1, 5'd5, 32'h12345678, 5'd5, 5'd6);
    checks++;
    if (ReadData1 !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL reset_cycle_no_bypass got %h want deadbeef", ReadData1);
    end
    step();
    reset_n = 1'b1;
    set_in(1'b0, 5'd0, 32'd0, 5'd5, 5'd5);
    checks++;
    if (ReadData1 !== 32'd0) begin
      failures++;
      $display("FAIL reset_clear got %h want 0", ReadData1);
    end
    $display("test_reset done");
  endtask

  task automatic test_write_read_all();
    for (int i = 0; i < 31; i++) begin
      set_in(1'b1, 5'(i), 32'hA5A50000 + i, 5'(i), 5'(30 - i));
      checks++;
      if (ReadData1 !== 32'hA5A50000 + i || ReadData2 !== exp_rd(5'(30 - i))) begin
        failures++;
        $display("FAIL write_all_bypass i=%0d got rd1=%h rd2=%h want %h %h",
                 i, ReadData1, ReadData2, 32'hA5A50000 + i, exp_rd(5'(30 - i)));
      end
      step();
    end
    for (int a = 0; a < 32; a++) begin
      logic [31:0] want1;
      logic [31:0] want2;
      set_in(1'b0, 5'd0, 32'd0, 5'(a), 5'(31 - a));
      want1 = (a == 31) ? 32'd0 : 32'hA5A50000 + a;
      want2 = (a == 0) ? 32'd0 : 32'hA5A50000 + (31 - a);
      checks++;
      if (ReadData1 !== want1 || ReadData2 !== want2) begin
        failures++;
        $display("FAIL read_all addr=%0d got rd1=%h rd2=%h want %h %h",
                 a, ReadData1, ReadData2, want1, want2);
      end
    end
    $display("test_write_read_all done");
  endtask

  task automatic test_zero_reg();
    set_in(1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd5);
    checks++;
    if (ReadData1 !== 32'd0) begin
      failures++;
      $display("FAIL zero_same_cycle got %h want 0", ReadData1);
    end
    step();
    for (int a = 0; a < 32; a++) begin
      set_in(1'b0, 5'd0, 32'd0, 5'(a), 5'd31);
      checks++;
      if (ReadData1 !== exp_rd(5'(a)) || ReadData2 !== 32'd0) begin
        failures++;
        $display("FAIL zero_no_change addr=%0d got rd1=%h rd2=%h want %h 0",
                 a, ReadData1, ReadData2, exp_rd(5'(a)));
      end
    end
    $display("test_zero_reg done");
  endtask

  task automatic test_bypass();
    set_in(1'b1, 5'd7, 32'h11111111, 5'd0, 5'd0);
    step();
    set_in(1'b1, 5'd7, 32'h22222222, 5'd7, 5'd8);
    checks++;
    if (ReadData1 !== 32'h22222222 || ReadData2 !== model[8]) begin
      failures++;
      $display("FAIL bypass_on got rd1=%h rd2=%h want 22222222 %h", ReadData1, ReadData2, model[8]);
    end
    step();
    set_in(1'b1, 5'd7, 32'h11111111, 5'd0, 5'd0);
    step();
    set_in(1'b0, 5'd7, 32'h22222222, 5'd7, 5'd8);
    checks++;
    if (ReadData1 !== 32'h11111111) begin
      failures++;
      $display("FAIL bypass_off got %h want 11111111", ReadData1);
    end
    step();
    $display("test_bypass done");
  endtask

  task automatic test_collision();
    set_in(1'b1, 5'd12, 32'h0F0F0F0F, 5'd0, 5'd0);
    step();
    set_in(1'b0, 5'd0, 32'd0, 5'd12, 5'd12);
    checks++;
    if (ReadData1 !== 32'h0F0F0F0F || ReadData2 !== 32'h0F0F0F0F) begin
      failures++;
      $display("FAIL collision_read got %h %h want 0f0f0f0f", ReadData1, ReadData2);
    end
    set_in(1'b1, 5'd12, 32'hF0F0F0F0, 5'd12, 5'd12);
    checks++;
    if (ReadData1 !== 32'hF0F0F0F0 || ReadData2 !== 32'hF0F0F0F0) begin
      failures++;
      $display("FAIL collision_bypass got %h %h want f0f0f0f0", ReadData1, ReadData2);
    end
    step();
    $display("test_collision done");
  endtask

  task automatic test_bit4_boundary();
    set_in(1'b1, 5'd15, 32'h0000FFFF, 5'd0, 5'd0);
    step();
    set_in(1'b1, 5'd16, 32'hFFFF0000, 5'd0, 5'd0);
    step();
    set_in(1'b0, 5'd0, 32'd0, 5'd15, 5'd16);
    checks++;
    if (ReadData1 !== 32'h0000FFFF || ReadData2 !== 32'hFFFF0000) begin
      failures++;
      $display("FAIL bit4_boundary got %h %h want 0000ffff ffff0000", ReadData1, ReadData2);
    end
    step();
    set_in(1'b0, 5'd0, 32'd0, 5'd16, 5'd15);
    checks++;
    if (ReadData1 !== 32'hFFFF0000 || ReadData2 !== 32'h0000FFFF) begin
      failures++;
      $display("FAIL bit4_swap got %h %h want ffff0000 0000ffff", ReadData1, ReadData2);
    end
    step();
    $display("test_bit4_boundary done");
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      reset_n = ($urandom_range(0, 39) != 0);
      set_in(1'($urandom_range(0, 2) != 0), 5'($urandom), $urandom,
             5'($urandom), ($urandom_range(0, 3) == 0) ? WriteReg : 5'($urandom));
      checks++;
      if (ReadData1 !== exp_rd(ReadReg1) || ReadData2 !== exp_rd(ReadReg2)) begin
        failures++;
        $display("FAIL random n=%0d rst_n=%0b we=%0b wa=%0d a1=%0d a2=%0d got %h %h want %h %h",
                 n, reset_n, RegWrite, WriteReg, ReadReg1, ReadReg2,
                 ReadData1, ReadData2, exp_rd(ReadReg1), exp_rd(ReadReg2));
      end
      step();
    end
    reset_n = 1'b1;
    $display("test_random done");
  endtask

  initial begin
    reset_n = 1'b1;
    set_in(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    @(posedge clk);
    #1;
    test_reset();
    test_write_read_all();
    test_zero_reg();
    test_bypass();
    test_collision();
    test_bit4_boundary();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
